adder_rr_scheduler: RTL and testbench

//   Shares one adder_256 instance among NREQ requesters in the conv engine.

---
 rtl/adder_rr_scheduler.sv | 126 ++++++++++++
 tb/tb_adder_rr_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler.sv
// Round-robin front end that time-shares one external adder among NREQ requesters.
// One operation in flight; request and response sides use valid/ready handshakes.
module adder_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int DW      = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_a,
    input  logic [NREQ*DW-1:0]       req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic [DW-1:0]            add_a,
    output logic [DW-1:0]            add_b,
    output logic                     add_en,
    input  logic [DW-1:0]            add_sum,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [DW-1:0]            rsp_sum
);
    localparam int IDW = $clog2(NREQ);
    localparam int LW  = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                  state_q;
    logic [IDW-1:0]          ptr_q;
    logic [IDW-1:0]          id_q;
    logic [LW-1:0]           lat_q;
    logic [DW-1:0]           opa_q;
    logic [DW-1:0]           opb_q;
    logic [DW-1:0]           sum_q;
    logic                    add_en_q;
    logic                    rsp_valid_q;

    logic [NREQ-1:0][DW-1:0] a_v;
    logic [NREQ-1:0][DW-1:0] b_v;
    logic                    gnt_vld_d;
    logic [IDW-1:0]          gnt_idx_d;

    assign a_v = req_a;
    assign b_v = req_b;

    // Walk from the highest offset down so the last hit is the one closest to ptr.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_idx_d = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr_q) + k) % NREQ]) begin
                gnt_vld_d = 1'b1;
                gnt_idx_d = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    // Grant is masked while reset is asserted so no handshake can complete then.
    always_comb begin
        req_ready = '0;
        if (rst && state_q == S_IDLE && gnt_vld_d)
            req_ready[gnt_idx_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            lat_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            sum_q       <= '0;
            add_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld_d) begin
                        opa_q    <= a_v[gnt_idx_d];
                        opb_q    <= b_v[gnt_idx_d];
                        id_q     <= gnt_idx_d;
                        add_en_q <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    add_en_q <= 1'b0;
                    if (ADD_LAT == 0) begin
                        sum_q       <= add_sum;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        lat_q   <= LW'(ADD_LAT - 1);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_q == '0) begin
                        sum_q       <= add_sum;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign add_a     = opa_q;
    assign add_b     = opb_q;
    assign add_en    = add_en_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: cycle-level reference model plus response scoreboard,
// with a second ADD_LAT=0 instance for the combinational-adder case.
module tb_adder_rr_scheduler;
    localparam int NREQ = 4;
    localparam int DW   = 4;
    localparam int LAT  = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]          req_valid = '0;
    logic [NREQ-1:0][DW-1:0]  ra = '0, rb = '0;
    logic [NREQ-1:0]          req_ready;
    logic [DW-1:0]            add_a, add_b, add_sum, sum_r;
    logic                     add_en, rsp_valid;
    logic                     rsp_ready = 1'b1;
    logic [1:0]               rsp_id;
    logic [DW-1:0]            rsp_sum;

    logic [NREQ-1:0]          req_valid0 = '0;
    logic [NREQ-1:0][DW-1:0]  ra0 = '0, rb0 = '0;
    logic [NREQ-1:0]          req_ready0;
    logic [DW-1:0]            add_a0, add_b0, add_sum0;
    logic                     add_en0, rsp_valid0;
    logic                     rsp_ready0 = 1'b1;
    logic [1:0]               rsp_id0;
    logic [DW-1:0]            rsp_sum0;

    adder_rr_scheduler #(.NREQ(NREQ), .DW(DW), .ADD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(ra), .req_b(rb),
        .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_en(add_en),
        .add_sum(add_sum), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum));

    adder_rr_scheduler #(.NREQ(NREQ), .DW(DW), .ADD_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_a(ra0), .req_b(rb0),
        .req_ready(req_ready0), .add_a(add_a0), .add_b(add_b0), .add_en(add_en0),
        .add_sum(add_sum0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_id(rsp_id0), .rsp_sum(rsp_sum0));

    // External adders: one-cycle registered on C_EN, and purely combinational.
    always @(posedge clk) if (add_en) sum_r <= add_a + add_b;
    assign add_sum  = sum_r;
    assign add_sum0 = add_a0 + add_b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    typedef struct { int id; int sum; } exp_t;
    exp_t exp_q[$];

    // Reference model: tracks idle/busy, age since accept, and the rr pointer.
    bit busy = 0, rst_seen = 0;
    int age = 0, m_ptr = 0, cur_id = 0, cur_a = 0, cur_b = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_in_reset", int'(req_ready), 0);
            busy = 0; m_ptr = 0; rst_seen = 1;
            exp_q.delete();
        end else begin
            if (rst_seen) begin
                chk("rst_add_en", int'(add_en), 0);
                chk("rst_rsp_valid", int'(rsp_valid), 0);
                chk("rst_rsp_id", int'(rsp_id), 0);
                chk("rst_rsp_sum", int'(rsp_sum), 0);
                chk("rst_add_a", int'(add_a), 0);
                chk("rst_add_b", int'(add_b), 0);
                rst_seen = 0;
            end
            if (busy) begin
                age++;
                chk("busy_ready", int'(req_ready), 0);
                chk("add_en", int'(add_en), (age == 1) ? 1 : 0);
                if (age >= 1 && age < 2 + LAT) begin
                    chk("add_a", int'(add_a), cur_a);
                    chk("add_b", int'(add_b), cur_b);
                end
                chk("rsp_valid", int'(rsp_valid), (age >= 2 + LAT) ? 1 : 0);
                if (age >= 2 + LAT) begin
                    chk("rsp_id_hold", int'(rsp_id), cur_id);
                    chk("rsp_sum_hold", int'(rsp_sum), (cur_a + cur_b) % 16);
                    if (rsp_ready) begin
                        busy = 0;
                        m_ptr = (cur_id + 1) % NREQ;
                    end
                end
            end else begin
                int g;
                g = pick(req_valid, m_ptr);
                chk("grant", int'(req_ready), (g < 0) ? 0 : (1 << g));
                chk("idle_add_en", int'(add_en), 0);
                chk("idle_rsp_valid", int'(rsp_valid), 0);
                if (g >= 0) begin
                    cur_id = g; cur_a = int'(ra[g]); cur_b = int'(rb[g]);
                    exp_q.push_back('{id: g, sum: (cur_a + cur_b) % 16});
                    busy = 1; age = 0;
                end
            end
        end
    end

    // Scoreboard monitor: pops on every completed response handshake.
    int last_id = -1, last_sum = -1;
    int id_log[$];
    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_spurious: got response id %0d with no expected entry", rsp_id);
            end else begin
                e = exp_q.pop_front();
                chk("sb_id", int'(rsp_id), e.id);
                chk("sb_sum", int'(rsp_sum), e.sum);
            end
            last_id = int'(rsp_id);
            last_sum = int'(rsp_sum);
            id_log.push_back(int'(rsp_id));
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0; req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Present a single request for one cycle (it is granted immediately when idle).
    task automatic one_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(posedge clk); #1;
        req_valid = '0; req_valid[i] = 1'b1; ra[i] = a; rb[i] = b;
        @(posedge clk); #1 req_valid = '0;
    endtask

    initial begin
        int exp5;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        one_req(0, 4'b1010, 4'b1111);
        repeat (4) @(posedge clk);
        chk("t1_sum", last_sum, 4'b1001);
        chk("t1_id", last_id, 0);

        last_sum = -1;
        one_req(2, 4'b0110, 4'b0110);
        repeat (4) @(posedge clk);
        chk("t2_sum", last_sum, 4'b1100);
        chk("t2_id", last_id, 2);

        do_reset();
        id_log.delete();
        @(posedge clk); #1 req_valid = 4'b1111;
        for (int c = 0; c < 22; c++) begin
            for (int i = 0; i < NREQ; i++) begin ra[i] = DW'($urandom); rb[i] = DW'($urandom); end
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (6) @(posedge clk);
        chk("t3_count", (id_log.size() >= 5) ? 1 : 0, 1);
        for (int n = 0; n < 5 && n < id_log.size(); n++)
            chk("t3_order", id_log[n], n % NREQ);

        #1 rsp_ready = 1'b0;
        one_req(3, 4'b0011, 4'b0101);
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        chk("t4_sum", last_sum, 4'b1000);
        chk("t4_id", last_id, 3);

        one_req(3, 4'b0001, 4'b0001);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        last_id = -1;
        repeat (3) @(posedge clk);
        chk("t5_no_rsp", last_id, -1);
        #1 req_valid = 4'b0110;
        ra[1] = DW'($urandom); rb[1] = DW'($urandom);
        ra[2] = DW'($urandom); rb[2] = DW'($urandom);
        exp5 = (int'(ra[1]) + int'(rb[1])) % 16;
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);
        chk("t5_id", last_id, 1);
        chk("t5_sum", last_sum, exp5);

        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin ra[i] = DW'($urandom); rb[i] = DW'($urandom); end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        #1 req_valid = '0; rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        chk("drain_empty", exp_q.size(), 0);

        @(posedge clk); #1;
        req_valid0 = 4'b0010; ra0[1] = 4'b1111; rb0[1] = 4'b0001; rsp_ready0 = 1'b1;
        @(negedge clk);
        chk("t6_ready", int'(req_ready0), 4'b0010);
        @(posedge clk); #1 req_valid0 = '0;
        @(negedge clk);
        chk("t6_add_en", int'(add_en0), 1);
        chk("t6_add_a", int'(add_a0), 4'b1111);
        chk("t6_early_valid", int'(rsp_valid0), 0);
        @(negedge clk);
        chk("t6_valid", int'(rsp_valid0), 1);
        chk("t6_sum", int'(rsp_sum0), 0);
        chk("t6_id", int'(rsp_id0), 1);
        @(negedge clk);
        chk("t6_done", int'(rsp_valid0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
